// File: rtl/bin2bcd_rx_if.sv
// Valid/ready link between the MRU buffer (master) and the BCD converter (slave).
// The buffer holds valid_i/data_i until it sees the one-cycle rdy_o acknowledge.
interface bin2bcd_rx_if #(
    parameter int WIDTH = 20
);
    logic             valid_i;
    logic [WIDTH-1:0] data_i;
    logic             rdy_o;

    modport master (output valid_i, output data_i, input rdy_o);
    modport slave  (input valid_i, input data_i, output rdy_o);
endinterface

// File: rtl/bin2bcd_rx.sv
// Accepts a binary word over the valid/ready link and converts it to packed BCD
// by sequential double-dabble, publishing digits plus a leading-zero blank mask.
module bin2bcd_rx #(
    parameter int WIDTH  = 20,
    parameter int DIGITS = 7
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    bin2bcd_rx_if.slave           link,
    output logic                  busy_o,
    output logic [4*DIGITS-1:0]   bcd_o,
    output logic [DIGITS-1:0]     blank_o,
    output logic                  bcd_valid_o
);
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t              state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [WIDTH-1:0]    bin_sr_q;
    logic [4*DIGITS-1:0] acc_q;
    logic                armed_q;
    logic                rdy_q;
    logic                busy_q;
    logic [4*DIGITS-1:0] bcd_q;
    logic [DIGITS-1:0]   blank_q;
    logic                bcd_valid_q;

    logic [4*DIGITS-1:0] acc_adj_d;
    logic [4*DIGITS-1:0] acc_shift_d;
    logic [DIGITS-1:0]   blank_d;
    logic [DIGITS:1]     zero_from;

    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_adj
            assign acc_adj_d[4*gi +: 4] = (acc_q[4*gi +: 4] >= 4'd5) ? acc_q[4*gi +: 4] + 4'd3
                                                                    : acc_q[4*gi +: 4];
        end
        // zero_from[k]: digits k..DIGITS-1 of the finished accumulator are all zero
        assign zero_from[DIGITS] = 1'b1;
        for (gi = 1; gi < DIGITS; gi++) begin : g_blank
            assign zero_from[gi] = (acc_q[4*gi +: 4] == 4'd0) && zero_from[gi+1];
            assign blank_d[gi]   = zero_from[gi];
        end
    endgenerate
    assign blank_d[0] = 1'b0;

    assign acc_shift_d = {acc_adj_d[4*DIGITS-2:0], bin_sr_q[WIDTH-1]};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            bin_sr_q    <= '0;
            acc_q       <= '0;
            armed_q     <= 1'b1;
            rdy_q       <= 1'b0;
            busy_q      <= 1'b0;
            bcd_q       <= '0;
            blank_q     <= {{(DIGITS-1){1'b1}}, 1'b0};
            bcd_valid_q <= 1'b0;
        end else if (en) begin
            rdy_q       <= 1'b0;
            bcd_valid_q <= 1'b0;
            // A producer still holding valid after its ack must drop it before re-arming
            if (state_q == IDLE && link.valid_i && armed_q)
                armed_q <= 1'b0;
            else if (!link.valid_i)
                armed_q <= 1'b1;
            case (state_q)
                IDLE: begin
                    if (link.valid_i && armed_q) begin
                        bin_sr_q <= link.data_i;
                        acc_q    <= '0;
                        cnt_q    <= '0;
                        rdy_q    <= 1'b1;
                        busy_q   <= 1'b1;
                        state_q  <= SHIFT;
                    end
                end
                SHIFT: begin
                    acc_q    <= acc_shift_d;
                    bin_sr_q <= bin_sr_q << 1;
                    cnt_q    <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(WIDTH-1))
                        state_q <= DONE;
                end
                DONE: begin
                    bcd_q       <= acc_q;
                    blank_q     <= blank_d;
                    bcd_valid_q <= 1'b1;
                    busy_q      <= 1'b0;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end else begin
            rdy_q       <= 1'b0;
            bcd_valid_q <= 1'b0;
        end
    end

    assign link.rdy_o  = rdy_q;
    assign busy_o      = busy_q;
    assign bcd_o       = bcd_q;
    assign blank_o     = blank_q;
    assign bcd_valid_o = bcd_valid_q;
endmodule
